pingpong_frame_ctrl: RTL and testbench

//  Sequencer and arbiter for the two note-position RAM banks used for double buffering.
//  A writer (map/y update logic) streams one complete frame of DEPTH y values into the back bank.
//  The VGA reader fetches from the front bank.

---
 rtl/pingpong_pkg.sv | 18 +
 rtl/pingpong_bank_mux.sv | 91 +++++++++
 rtl/pingpong_frame_ctrl.sv | 131 +++++++++++++
 tb/tb_pingpong_frame_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong frame controller.
//   wr_state_e : write-side FSM state (FILL = accepting a frame, FULL = back bank complete)
//   REPEAT_MAX : saturation value of the repeat counter
//   sat_inc8   : saturating increment used by the repeat counter
package pingpong_pkg;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } wr_state_e;

   localparam logic [7:0] REPEAT_MAX = 8'd255;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == REPEAT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/pingpong_bank_mux.sv
// Routes the writer and the reader to the two RAM banks.
// The back bank (~front_sel) receives writes; the front bank receives reads.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   front_sel              bank currently displayed
//   wr_en/wr_addr/wr_data  accepted write request (goes to the back bank)
//   rd_en/rd_addr          read request (goes to the front bank)
//   rd_valid/rd_y          read response, one cycle after rd_en
//   bankN_*                RAM ports of bank0/bank1 (rdata has 1-cycle latency)
module pingpong_bank_mux
   import pingpong_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 160,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          front_sel,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_valid,
   output logic [DW-1:0] rd_y,
   output logic [AW-1:0] bank0_addr,
   output logic [DW-1:0] bank0_wdata,
   output logic          bank0_we,
   output logic          bank0_re,
   input  logic [DW-1:0] bank0_rdata,
   output logic [AW-1:0] bank1_addr,
   output logic [DW-1:0] bank1_wdata,
   output logic          bank1_we,
   output logic          bank1_re,
   input  logic [DW-1:0] bank1_rdata
);

   logic          rd_in_range;
   logic [AW-1:0] addr_arr  [2];
   logic          we_arr    [2];
   logic          re_arr    [2];
   logic [DW-1:0] rdata_arr [2];

   logic          rd_valid_q;
   logic          rd_bank_q;
   logic          rd_hit_q;

   // Out-of-range reads never touch a RAM; they still answer with zero data.
   assign rd_in_range = ({1'b0, rd_addr} < (AW+1)'(DEPTH));

   // Front and back are always different banks, so no bank is ever read
   // and written in the same cycle.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic is_front;
      assign is_front      = (front_sel == 1'(gi));
      assign addr_arr[gi]  = is_front ? rd_addr : wr_addr;
      assign we_arr[gi]    = wr_en & ~is_front;
      assign re_arr[gi]    = rd_en & rd_in_range & is_front;
   end

   assign bank0_addr   = addr_arr[0];
   assign bank0_wdata  = wr_data;
   assign bank0_we     = we_arr[0];
   assign bank0_re     = re_arr[0];
   assign bank1_addr   = addr_arr[1];
   assign bank1_wdata  = wr_data;
   assign bank1_we     = we_arr[1];
   assign bank1_re     = re_arr[1];
   assign rdata_arr[0] = bank0_rdata;
   assign rdata_arr[1] = bank1_rdata;

   // The bank chosen at request time is captured with the request, so a read
   // issued in the swap cycle is answered from the old front bank.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_valid_q <= 1'b0;
         rd_bank_q  <= 1'b0;
         rd_hit_q   <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         rd_bank_q  <= front_sel;
         rd_hit_q   <= rd_en & rd_in_range;
      end
   end

   // The RAM output register supplies the data; only the select is held here.
   assign rd_valid = rd_valid_q;
   assign rd_y     = rd_hit_q ? rdata_arr[rd_bank_q] : '0;

endmodule

// File: rtl/pingpong_frame_ctrl.sv
// Double-buffer sequencer for the note-position RAM banks.
// The writer fills the back bank with one frame of DEPTH entries; the banks
// swap on frame_start only when that frame is complete, otherwise the old
// frame is shown again and repeat_cnt counts the miss.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   frame_start          vertical-blank pulse
//   wr_valid/wr_y/wr_ready  writer handshake
//   rd_en/rd_addr        reader request; rd_valid/rd_y response one cycle later
//   front_sel            displayed bank, repeat_cnt saturating miss counter
//   bankN_*              RAM ports of bank0/bank1
module pingpong_frame_ctrl
   import pingpong_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 160,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          frame_start,
   input  logic          wr_valid,
   input  logic [DW-1:0] wr_y,
   output logic          wr_ready,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_valid,
   output logic [DW-1:0] rd_y,
   output logic          front_sel,
   output logic [7:0]    repeat_cnt,
   output logic [AW-1:0] bank0_addr,
   output logic [DW-1:0] bank0_wdata,
   output logic          bank0_we,
   output logic          bank0_re,
   input  logic [DW-1:0] bank0_rdata,
   output logic [AW-1:0] bank1_addr,
   output logic [DW-1:0] bank1_wdata,
   output logic          bank1_we,
   output logic          bank1_re,
   input  logic [DW-1:0] bank1_rdata
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   wr_state_e     state_q, state_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic          front_sel_q, front_sel_d;
   logic [7:0]    repeat_cnt_q, repeat_cnt_d;

   logic          wr_fire;
   logic          last_wr;
   logic          swap;
   logic          repeat_hit;

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) state_q <= FILL;
      else         state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL: if (last_wr)     state_d = FULL;
         FULL: if (frame_start) state_d = FILL;
      endcase
   end

   // Outputs
   always_comb begin
      wr_ready = (state_q == FILL);
   end

   assign wr_fire = wr_valid & wr_ready;
   assign last_wr = wr_fire & (wr_addr_q == LAST_ADDR);
   // Both decisions look at the registered state: a final write coinciding
   // with frame_start counts as a repeat, and the swap waits for the next pulse.
   assign swap       = frame_start & (state_q == FULL);
   assign repeat_hit = frame_start & (state_q == FILL);

   always_comb begin
      wr_addr_d    = wr_addr_q;
      front_sel_d  = front_sel_q ^ swap;
      repeat_cnt_d = repeat_hit ? sat_inc8(repeat_cnt_q) : repeat_cnt_q;
      if (wr_fire) wr_addr_d = last_wr ? '0 : wr_addr_q + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_addr_q    <= '0;
         front_sel_q  <= 1'b0;
         repeat_cnt_q <= 8'd0;
      end else begin
         wr_addr_q    <= wr_addr_d;
         front_sel_q  <= front_sel_d;
         repeat_cnt_q <= repeat_cnt_d;
      end
   end

   assign front_sel  = front_sel_q;
   assign repeat_cnt = repeat_cnt_q;

   pingpong_bank_mux #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_bank_mux (
      .clk         (clk),
      .resetn      (resetn),
      .front_sel   (front_sel_q),
      .wr_en       (wr_fire),
      .wr_addr     (wr_addr_q),
      .wr_data     (wr_y),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_valid    (rd_valid),
      .rd_y        (rd_y),
      .bank0_addr  (bank0_addr),
      .bank0_wdata (bank0_wdata),
      .bank0_we    (bank0_we),
      .bank0_re    (bank0_re),
      .bank0_rdata (bank0_rdata),
      .bank1_addr  (bank1_addr),
      .bank1_wdata (bank1_wdata),
      .bank1_we    (bank1_we),
      .bank1_re    (bank1_re),
      .bank1_rdata (bank1_rdata)
   );

endmodule

// File: tb/tb_pingpong_frame_ctrl.sv
// Bench for pingpong_frame_ctrl: directed scenarios plus a randomized run,
// checked against a frame-level reference model (bank contents, fill count,
// full flag, displayed bank, repeat count).
module tb_pingpong_frame_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 160;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          frame_start = 1'b0;
   logic          wr_valid = 1'b0;
   logic [DW-1:0] wr_y = '0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          wr_ready, rd_valid, front_sel;
   logic [DW-1:0] rd_y;
   logic [7:0]    repeat_cnt;
   logic [AW-1:0] bank0_addr, bank1_addr;
   logic [DW-1:0] bank0_wdata, bank1_wdata;
   logic          bank0_we, bank0_re, bank1_we, bank1_re;
   logic [DW-1:0] bank0_rdata = '0, bank1_rdata = '0;

   always #5 clk = ~clk;

   pingpong_frame_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .resetn(resetn), .frame_start(frame_start),
      .wr_valid(wr_valid), .wr_y(wr_y), .wr_ready(wr_ready),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_y(rd_y),
      .front_sel(front_sel), .repeat_cnt(repeat_cnt),
      .bank0_addr(bank0_addr), .bank0_wdata(bank0_wdata), .bank0_we(bank0_we),
      .bank0_re(bank0_re), .bank0_rdata(bank0_rdata),
      .bank1_addr(bank1_addr), .bank1_wdata(bank1_wdata), .bank1_we(bank1_we),
      .bank1_re(bank1_re), .bank1_rdata(bank1_rdata)
   );

   // Synchronous RAMs with one-cycle read latency
   logic [DW-1:0] ram0 [0:255];
   logic [DW-1:0] ram1 [0:255];
   initial for (int i = 0; i < 256; i++) begin ram0[i] = '0; ram1[i] = '0; end
   always @(posedge clk) begin
      if (bank0_we) ram0[bank0_addr] <= bank0_wdata;
      if (bank0_re) bank0_rdata <= ram0[bank0_addr];
      if (bank1_we) ram1[bank1_addr] <= bank1_wdata;
      if (bank1_re) bank1_rdata <= ram1[bank1_addr];
   end

   // Reference model
   logic [DW-1:0] exp_mem [0:1][0:DEPTH-1];
   int            m_front = 0;
   int            m_full  = 0;
   int            m_cnt   = 0;
   int            m_rep   = 0;
   bit            m_pv    = 0;
   logic [DW-1:0] m_py    = '0;

   int n_cmp = 0;
   int n_bad = 0;

   initial for (int b = 0; b < 2; b++) for (int i = 0; i < DEPTH; i++) exp_mem[b][i] = '0;

   // Advance one clock and apply the frame rules to the model
   task automatic tick();
      int  of, ofull;
      bit  fire;
      @(posedge clk);
      of    = m_front;
      ofull = m_full;
      fire  = resetn && wr_valid && (ofull == 0);
      if (!resetn) begin
         m_front = 0; m_full = 0; m_cnt = 0; m_rep = 0; m_pv = 0; m_py = '0;
      end else begin
         m_pv = rd_en;
         m_py = (rd_en && int'(rd_addr) < DEPTH) ? exp_mem[of][int'(rd_addr)] : '0;
         if (frame_start) begin
            if (ofull != 0) begin m_front = 1 - of; m_full = 0; end
            else if (m_rep < 255) m_rep++;
         end
         if (fire) begin
            exp_mem[1-of][m_cnt] = wr_y;
            m_cnt++;
            if (m_cnt == DEPTH) begin m_cnt = 0; m_full = 1; end
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      wr_valid = 0; frame_start = 0; rd_en = 0;
   endtask

   task automatic test_reset();
      resetn = 0; idle_inputs(); rd_en = 1;
      tick(); tick();
      resetn = 1; rd_en = 0; #1;
      n_cmp++;
      if ({front_sel, wr_ready, rd_valid, repeat_cnt} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
         n_bad++; $display("FAIL reset_state: got fs=%0b rdy=%0b rv=%0b rep=%0d want 0 1 0 0",
                           front_sel, wr_ready, rd_valid, repeat_cnt);
      end
      n_cmp++;
      if ({bank0_we, bank0_re, bank1_we, bank1_re, rd_y} !== '0) begin
         n_bad++; $display("FAIL reset_bank: got we/re=%b%b%b%b rd_y=%0d want all 0",
                           bank0_we, bank0_re, bank1_we, bank1_re, rd_y);
      end
      $display("test_reset done");
   endtask

   task automatic test_fill_swap();
      for (int i = 0; i < DEPTH; i++) begin
         wr_valid = 1; wr_y = DW'(i); #1;
         n_cmp++;
         if ({bank0_we, bank1_we, bank1_addr, bank1_wdata} !== {1'b0, 1'b1, AW'(i), DW'(i)}) begin
            n_bad++; $display("FAIL fill_write[%0d]: got we0=%0b we1=%0b a=%0d d=%0d want 0 1 %0d %0d",
                              i, bank0_we, bank1_we, bank1_addr, bank1_wdata, i, i);
         end
         tick();
      end
      wr_valid = 0; #1;
      n_cmp++;
      if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full_ready: got %0b want 0", wr_ready); end
      frame_start = 1; tick(); frame_start = 0; #1;
      n_cmp++;
      if ({front_sel, wr_ready} !== 2'b11) begin
         n_bad++; $display("FAIL swap: got fs=%0b rdy=%0b want 1 1", front_sel, wr_ready);
      end
      rd_en = 1; rd_addr = 8'd5; tick(); rd_en = 0; #1;
      n_cmp++;
      if ({rd_valid, rd_y} !== {1'b1, 8'd5}) begin
         n_bad++; $display("FAIL read_addr5: got rv=%0b y=%0d want 1 5", rd_valid, rd_y);
      end
      $display("test_fill_swap done");
   endtask

   task automatic test_partial_repeat();
      for (int i = 0; i < 100; i++) begin wr_valid = 1; wr_y = DW'($urandom); tick(); end
      wr_valid = 0; frame_start = 1; tick(); frame_start = 0; #1;
      n_cmp++;
      if ({front_sel, repeat_cnt, wr_ready} !== {1'b1, 8'd1, 1'b1}) begin
         n_bad++; $display("FAIL partial_repeat: got fs=%0b rep=%0d rdy=%0b want 1 1 1",
                           front_sel, repeat_cnt, wr_ready);
      end
      wr_valid = 1; wr_y = DW'($urandom); #1;
      n_cmp++;
      if ({bank0_we, bank0_addr, bank1_we} !== {1'b1, 8'd100, 1'b0}) begin
         n_bad++; $display("FAIL partial_continue: got we0=%0b a=%0d we1=%0b want 1 100 0",
                           bank0_we, bank0_addr, bank1_we);
      end
      tick();
      for (int i = 101; i < DEPTH; i++) begin wr_y = DW'($urandom); tick(); end
      wr_valid = 0;
      $display("test_partial_repeat done");
   endtask

   task automatic test_full_hold();
      wr_valid = 1;
      for (int c = 0; c < 10; c++) begin
         wr_y = DW'($urandom); #1;
         n_cmp++;
         if ({wr_ready, bank0_we, bank1_we} !== 3'b000) begin
            n_bad++; $display("FAIL full_hold[%0d]: got rdy=%0b we0=%0b we1=%0b want 0 0 0",
                              c, wr_ready, bank0_we, bank1_we);
         end
         tick();
      end
      wr_valid = 0;
      $display("test_full_hold done");
   endtask

   task automatic test_final_with_frame();
      frame_start = 1; tick(); frame_start = 0;   // front -> bank0, back = bank1
      for (int i = 0; i < DEPTH - 1; i++) begin wr_valid = 1; wr_y = DW'(8'h50 + i); tick(); end
      wr_y = DW'(8'h50 + DEPTH - 1); frame_start = 1; tick();
      wr_valid = 0; frame_start = 0; #1;
      n_cmp++;
      if ({wr_ready, front_sel, repeat_cnt} !== {1'b0, 1'b0, 8'd2}) begin
         n_bad++; $display("FAIL final_plus_frame: got rdy=%0b fs=%0b rep=%0d want 0 0 2",
                           wr_ready, front_sel, repeat_cnt);
      end
      frame_start = 1; tick(); frame_start = 0; #1;
      n_cmp++;
      if ({front_sel, wr_ready} !== 2'b11) begin
         n_bad++; $display("FAIL final_next_swap: got fs=%0b rdy=%0b want 1 1", front_sel, wr_ready);
      end
      $display("test_final_with_frame done");
   endtask

   task automatic test_swap_read();
      // bank1 holds 0x50+i and is displayed; fill bank0 with 0xA0^i
      for (int i = 0; i < DEPTH; i++) begin wr_valid = 1; wr_y = DW'(8'hA0 ^ i); tick(); end
      wr_valid = 0;
      frame_start = 1; rd_en = 1; rd_addr = 8'd3; tick();
      frame_start = 0; #1;
      n_cmp++;
      if ({rd_valid, rd_y, front_sel} !== {1'b1, 8'h53, 1'b0}) begin
         n_bad++; $display("FAIL swap_cycle_read: got rv=%0b y=%h fs=%0b want 1 53 0",
                           rd_valid, rd_y, front_sel);
      end
      tick(); rd_en = 0; #1;
      n_cmp++;
      if ({rd_valid, rd_y} !== {1'b1, 8'hA3}) begin
         n_bad++; $display("FAIL post_swap_read: got rv=%0b y=%h want 1 a3", rd_valid, rd_y);
      end
      $display("test_swap_read done");
   endtask

   task automatic test_reset_midfill();
      for (int i = 0; i < DEPTH; i++) begin wr_valid = 1; wr_y = DW'($urandom); tick(); end
      wr_valid = 0; frame_start = 1; tick(); frame_start = 0;   // front -> bank1
      for (int i = 0; i < 80; i++) begin wr_valid = 1; wr_y = DW'($urandom); tick(); end
      wr_valid = 0; rd_en = 1; rd_addr = 8'd7; resetn = 0; tick();
      resetn = 1; rd_en = 0; #1;
      n_cmp++;
      if ({front_sel, repeat_cnt, wr_ready, rd_valid, rd_y} !== {1'b0, 8'd0, 1'b1, 1'b0, 8'd0}) begin
         n_bad++; $display("FAIL midfill_reset: got fs=%0b rep=%0d rdy=%0b rv=%0b y=%0d want 0 0 1 0 0",
                           front_sel, repeat_cnt, wr_ready, rd_valid, rd_y);
      end
      wr_valid = 1; wr_y = 8'h3C; #1;
      n_cmp++;
      if ({bank1_we, bank1_addr, bank0_we} !== {1'b1, 8'd0, 1'b0}) begin
         n_bad++; $display("FAIL midfill_next_write: got we1=%0b a=%0d we0=%0b want 1 0 0",
                           bank1_we, bank1_addr, bank0_we);
      end
      tick(); wr_valid = 0;
      $display("test_reset_midfill done");
   endtask

   task automatic test_random();
      bit            fire, in_rng;
      int            back;
      logic [12:0]   got, want;
      for (int c = 0; c < 3000; c++) begin
         wr_valid    = ($urandom_range(0, 3) != 0);
         wr_y        = DW'($urandom);
         frame_start = ($urandom_range(0, 59) == 0);
         rd_en       = $urandom_range(0, 1) != 0;
         rd_addr     = AW'($urandom_range(0, 175));
         #1;
         fire   = wr_valid && (m_full == 0);
         back   = 1 - m_front;
         in_rng = int'(rd_addr) < DEPTH;
         got  = {wr_ready, front_sel, repeat_cnt, bank0_we, bank1_we, bank0_re, bank1_re};
         want = {m_full == 0, m_front[0], 8'(m_rep), fire && back == 0, fire && back == 1,
                 rd_en && in_rng && m_front == 0, rd_en && in_rng && m_front == 1};
         n_cmp++;
         if (got !== want) begin
            n_bad++; $display("FAIL rand_ctrl[%0d]: got %b want %b", c, got, want);
         end
         if (fire) begin
            n_cmp++;
            if ((back == 0 ? {bank0_addr, bank0_wdata} : {bank1_addr, bank1_wdata}) !== {AW'(m_cnt), wr_y}) begin
               n_bad++; $display("FAIL rand_wr[%0d]: got a/d=%h/%h want %h/%h", c,
                                 back == 0 ? bank0_addr : bank1_addr,
                                 back == 0 ? bank0_wdata : bank1_wdata, AW'(m_cnt), wr_y);
            end
         end
         n_cmp++;
         if ({rd_valid, (m_pv ? rd_y : 8'd0)} !== {m_pv, m_py}) begin
            n_bad++; $display("FAIL rand_rd[%0d]: got rv=%0b y=%h want %0b %h", c, rd_valid, rd_y, m_pv, m_py);
         end
         tick();
      end
      idle_inputs();
      $display("test_random done");
   endtask

   task automatic test_saturate();
      // stay in a partial fill and pulse frame_start far beyond 255 times
      if (m_full != 0) begin frame_start = 1; tick(); end
      frame_start = 1; wr_valid = 0;
      for (int c = 0; c < 300; c++) tick();
      frame_start = 0; #1;
      n_cmp++;
      if (repeat_cnt !== 8'd255) begin
         n_bad++; $display("FAIL repeat_saturate: got %0d want 255", repeat_cnt);
      end
      $display("test_saturate done");
   endtask

   initial begin
      test_reset();
      test_fill_swap();
      test_partial_repeat();
      test_full_hold();
      test_final_with_frame();
      test_swap_read();
      test_reset_midfill();
      test_random();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation ran past 2000000 time units");
      $fatal(1, "timeout");
   end

endmodule
